port_age_buffer: RTL
====================

# port_age_buffer

Per-port input buffering stage in front of the age-based data ranking stage. It accepts 8-bit flits from four router input ports into independent FIFOs, tracks how many cycles each buffered flit has waited, and presents each port's head flit, head age and head-valid as the concatenated buses the ranking stage consumes. Downstream pops per port once a head flit has been forwarded.

## Interface
- DEPTH, 4, entries per port FIFO; power of two, ≥2
- STARVE_TH, 8'd200, head-age threshold for starvation flag (used only with STARVE_FLAG_EN)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- in_valid  input  4  per-port flit offered
- in_data  input  32  4 x 8-bit flits, port p at [8p+7:8p]
- in_ready  output  4  per-port FIFO can accept
- pop  input  4  per-port consume head flit
- input_valid  output  4  per-port head flit present
- age_of_data  output  32  4 x 8-bit head ages, port p at [8p+7:8p]
- input_data  output  32  4 x 8-bit head flits, port p at [8p+7:8p]
- starve  output  4  head age ≥ STARVE_TH (present only with STARVE_FLAG_EN)

## Operation
- Four identical, independent channels p = 0..3; each holds a DEPTH-entry circular FIFO of {data[7:0], age[7:0]}, wr/rd pointers of log2(DEPTH) bits plus an occupancy count 0..DEPTH.
- Push: in_valid[p] && in_ready[p] writes in_data[p] with age 0 at wr pointer; pointer wraps DEPTH-1 -> 0.
- Pop: pop[p] && input_valid[p] advances rd pointer (wraps). pop[p] on empty FIFO is ignored; no state change.
- Ageing: every clock edge, every occupied entry not being popped has age incremented by 1, saturating at 8'hFF (never wraps). The entry being written that edge gets 0.
- in_ready[p] = (count < DEPTH), from registered count only; a same-cycle pop does not raise in_ready (no pop->ready combinational path).
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Simultaneous push and pop on empty FIFO: pop ignored, push accepted, count becomes 1.
- Outputs: input_valid[p] = (count != 0); input_data/age_of_data lanes show head entry when valid, forced to 8'h00 when empty.
- Reset (asserted any time, including mid-transfer): all counts, pointers, ages cleared; stored flits discarded; in_ready = 4'hF once reset deasserts (0 while asserted), input_valid = 0, age_of_data = 0, input_data = 0, starve = 0.

## Timing
- Push at edge t -> head visible (if FIFO was empty) during cycle t+1 with age 0; age reads k in cycle t+1+k, up to 255.
- Pop at edge t -> next entry becomes head in cycle t+1 showing its already-accumulated age.
- All outputs registered-state-derived; no input-to-output combinational path except none (in_ready, input_valid, age_of_data, input_data depend only on state).
- Throughput: one push and one pop per port per cycle.

## Configuration
- STARVE_FLAG_EN defined: starve[3:0] port exists; starve[p] = input_valid[p] && (head age ≥ STARVE_TH), combinational from state; cleared by pop exposing a younger head or by reset.
- Not defined: starve port and comparison logic absent; all other behaviour identical.

## Test plan
- Reset then idle: reset low 3 cycles -> in_ready=0 during reset, 4'hF after; input_valid=0, both output buses 32'h0.
- Single push port 2 data 8'hA5 at edge 0, no pops -> cycle 1 input_valid=4'b0100, input_data[23:16]=8'hA5, age 0; cycle 11 age 10; after 256+ cycles age holds 8'hFF.
- Fill port 0 with DEPTH=4 flits 8'h01..04 -> in_ready[0]=0 after 4th push; 5th offer 8'h05 not accepted; pop 4 times -> heads 01,02,03,04 in order, then input_valid[0]=0.
- Concurrent push+pop on port 1 with count 2 for 10 cycles -> count stays 2, in_ready[1]=1, data order preserved across pointer wrap; pop on empty port 3 -> no change.
- Reset asserted mid-stream with all ports partially full -> all outputs zero immediately (asynchronous), previously stored flits never reappear after release.
- With STARVE_FLAG_EN, STARVE_TH=8'd5: push port 0, no pop -> starve[0] rises in cycle 6 (age 5), falls in cycle after pop; without macro, build compiles with no starve port.

Source files
------------

// File: rtl/port_age_buffer.sv
// port_age_buffer: four per-port flit FIFOs that track head-flit age; STARVE_FLAG_EN adds the starve output
module port_age_buffer #(
  parameter int DEPTH = 4
`ifdef STARVE_FLAG_EN
  , parameter logic [7:0] STARVE_TH = 8'd200
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_valid,
  input  logic [31:0] in_data,
  output logic [3:0]  in_ready,
  input  logic [3:0]  pop,
  output logic [3:0]  input_valid,
  output logic [31:0] age_of_data,
  output logic [31:0] input_data
`ifdef STARVE_FLAG_EN
  , output logic [3:0] starve
`endif
);
  localparam int AW = $clog2(DEPTH);
  genvar p;
  generate
    for (p = 0; p < 4; p++) begin : g_port
      logic [7:0] dmem [DEPTH];
      logic [7:0] amem [DEPTH];
      logic [AW-1:0] wr_ptr, rd_ptr;
      logic [AW:0] count;
      logic [DEPTH-1:0] occ;
      logic push, take;
      assign push = in_valid[p] && in_ready[p];
      assign take = pop[p] && input_valid[p];
      assign in_ready[p] = reset && (count < (AW+1)'(DEPTH));
      assign input_valid[p] = count != '0;
      assign input_data[8*p +: 8] = input_valid[p] ? dmem[rd_ptr] : 8'h00;
      assign age_of_data[8*p +: 8] = input_valid[p] ? amem[rd_ptr] : 8'h00;
`ifdef STARVE_FLAG_EN
      assign starve[p] = input_valid[p] && (amem[rd_ptr] >= STARVE_TH);
`endif
      // mark slots holding live flits: distance from the read pointer is below the occupancy
      always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) occ[i] = {1'b0, AW'(i) - rd_ptr} < count;
      end
      // FIFO storage, pointers and per-entry saturating age counters
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            dmem[i] <= 8'h00;
            amem[i] <= 8'h00;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (push && AW'(i) == wr_ptr) begin
              dmem[i] <= in_data[8*p +: 8];
              amem[i] <= 8'h00;
            end else if (occ[i] && !(take && AW'(i) == rd_ptr) && amem[i] != 8'hFF) begin
              amem[i] <= amem[i] + 8'd1;
            end
          end
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (take) rd_ptr <= rd_ptr + 1'b1;
          count <= count + (AW+1)'(push) - (AW+1)'(take);
        end
      end
    end
  endgenerate
endmodule
